// File: rtl/mem_load_stage.sv
// Memory/load pipeline stage: holds an EX result or waits for a data-SRAM response,
// then aligns and extends the loaded lane before handing it to write-back.
module mem_load_stage #(
   parameter int DATA_W = 32,
   parameter int RF_AW  = 5,
   parameter int PC_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              stall_hold,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PC_W-1:0]   in_pc,
   input  logic              in_rf_we,
   input  logic [RF_AW-1:0]  in_rf_waddr,
   input  logic [DATA_W-1:0] in_ex_result,
   input  logic              in_load,
   input  logic [1:0]        in_ld_size,
   input  logic              in_ld_signed,
   input  logic              rdata_valid,
   input  logic [DATA_W-1:0] rdata,
   output logic              out_valid,
   output logic [PC_W-1:0]   out_pc,
   output logic              out_rf_we,
   output logic [RF_AW-1:0]  out_rf_waddr,
   output logic [DATA_W-1:0] out_rf_wdata,
   output logic              out_adel,
   output logic              fwd_we,
   output logic [RF_AW-1:0]  fwd_waddr,
   output logic [DATA_W-1:0] fwd_wdata,
   output logic              fwd_pending,
   output logic              stallreq
);

   localparam int OFF_W = $clog2(DATA_W / 8);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_DONE  = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [PC_W-1:0]     pc_q, pc_d;
   logic                rf_we_q, rf_we_d;
   logic [RF_AW-1:0]    waddr_q, waddr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                adel_q, adel_d;
   logic [OFF_W-1:0]    off_q, off_d;
   logic [1:0]          size_q, size_d;
   logic                sgn_q, sgn_d;

   logic                in_ready_s;
   logic                accept_s;
   logic [OFF_W-1:0]    in_off_s;
   logic [OFF_W-1:0]    align_mask_s;
   logic                illegal_s;
   logic [DATA_W-1:0]   shifted_s;
   logic [6:0]          nbits_s;
   logic [DATA_W-1:0]   keep_s;
   logic                msb_s;
   logic [DATA_W-1:0]   ld_data_s;

   // Handshake and legality of the offered entry (dword is never legal on a 32-bit path).
   always_comb begin
      in_ready_s = ~rst & ((state_q == S_IDLE) | ((state_q == S_DONE) & ~stall_hold));
      accept_s   = in_valid & in_ready_s & ~flush;
      in_off_s   = in_ex_result[OFF_W-1:0];
      case (in_ld_size)
         2'd0:    align_mask_s = OFF_W'(3'd0);
         2'd1:    align_mask_s = OFF_W'(3'd1);
         2'd2:    align_mask_s = OFF_W'(3'd3);
         default: align_mask_s = OFF_W'(3'd7);
      endcase
      illegal_s = in_load & (((in_off_s & align_mask_s) != '0) |
                             ((in_ld_size == 2'd3) && (DATA_W == 32)));
   end

   // Lane extraction from the response using the offset/size captured at accept.
   always_comb begin
      shifted_s = rdata >> {off_q, 3'b000};
      nbits_s   = 7'd8 << size_q;
      keep_s    = ~({DATA_W{1'b1}} << nbits_s);
      case (size_q)
         2'd0:    msb_s = shifted_s[7];
         2'd1:    msb_s = shifted_s[15];
         2'd2:    msb_s = shifted_s[31];
         default: msb_s = shifted_s[DATA_W-1];
      endcase
      ld_data_s = (shifted_s & keep_s) | ((sgn_q & msb_s) ? ~keep_s : '0);
   end

   // Next-state and held-field update; flush outranks accept and response.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      rf_we_d = rf_we_q;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      adel_d  = adel_q;
      off_d   = off_q;
      size_d  = size_q;
      sgn_d   = sgn_q;
      if (flush) begin
         state_d = ((state_q == S_WAIT) || (state_q == S_DRAIN)) ? S_DRAIN : S_IDLE;
      end else if (accept_s) begin
         state_d = (in_load & ~illegal_s) ? S_WAIT : S_DONE;
         pc_d    = in_pc;
         rf_we_d = in_rf_we & ~illegal_s;
         waddr_d = in_rf_waddr;
         wdata_d = in_load ? '0 : in_ex_result;
         adel_d  = illegal_s;
         off_d   = in_off_s;
         size_d  = in_ld_size;
         sgn_d   = in_ld_signed;
      end else begin
         case (state_q)
            S_WAIT: begin
               if (rdata_valid) begin
                  wdata_d = ld_data_s;
                  state_d = S_DONE;
               end else begin
                  state_d = S_WAIT;
               end
            end
            S_DONE:  state_d = stall_hold ? S_DONE : S_IDLE;
            S_DRAIN: state_d = rdata_valid ? S_IDLE : S_DRAIN;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State and held-field registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         rf_we_q <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         adel_q  <= 1'b0;
         off_q   <= '0;
         size_q  <= 2'd0;
         sgn_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         rf_we_q <= rf_we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         adel_q  <= adel_d;
         off_q   <= off_d;
         size_q  <= size_d;
         sgn_q   <= sgn_d;
      end
   end

   assign in_ready     = in_ready_s;
   assign out_valid    = (state_q == S_DONE);
   assign out_pc       = pc_q;
   assign out_rf_we    = rf_we_q;
   assign out_rf_waddr = waddr_q;
   assign out_rf_wdata = wdata_q;
   assign out_adel     = adel_q;
   assign fwd_we       = (state_q == S_DONE) & rf_we_q;
   assign fwd_waddr    = waddr_q;
   assign fwd_wdata    = wdata_q;
   assign fwd_pending  = (state_q == S_WAIT);
   assign stallreq     = (state_q == S_WAIT) | (state_q == S_DRAIN);

endmodule

// File: tb/tb_mem_load_stage.sv
// Bench for mem_load_stage: directed scenarios plus random transactions on a 32-bit
// instance, and directed dword/word loads on a 64-bit instance.
module tb_mem_load_stage;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // 32-bit instance
   logic        rst, flush, stall_hold, in_valid, in_rf_we, in_load, in_ld_signed, rdata_valid;
   logic [31:0] in_pc, in_ex_result, rdata;
   logic [4:0]  in_rf_waddr;
   logic [1:0]  in_ld_size;
   logic        in_ready, out_valid, out_rf_we, out_adel, fwd_we, fwd_pending, stallreq;
   logic [31:0] out_pc, out_rf_wdata, fwd_wdata;
   logic [4:0]  out_rf_waddr, fwd_waddr;

   // 64-bit instance
   logic        rst_b, flush_b, stall_hold_b, in_valid_b, in_rf_we_b, in_load_b, in_ld_signed_b, rdata_valid_b;
   logic [31:0] in_pc_b;
   logic [63:0] in_ex_result_b, rdata_b;
   logic [4:0]  in_rf_waddr_b;
   logic [1:0]  in_ld_size_b;
   logic        in_ready_b, out_valid_b, out_rf_we_b, out_adel_b, fwd_we_b, fwd_pending_b, stallreq_b;
   logic [31:0] out_pc_b;
   logic [63:0] out_rf_wdata_b, fwd_wdata_b;
   logic [4:0]  out_rf_waddr_b, fwd_waddr_b;

   mem_load_stage #(.DATA_W(32), .RF_AW(5), .PC_W(32)) u_dut32 (
      .clk(clk), .rst(rst), .flush(flush), .stall_hold(stall_hold),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_rf_we(in_rf_we),
      .in_rf_waddr(in_rf_waddr), .in_ex_result(in_ex_result), .in_load(in_load),
      .in_ld_size(in_ld_size), .in_ld_signed(in_ld_signed),
      .rdata_valid(rdata_valid), .rdata(rdata),
      .out_valid(out_valid), .out_pc(out_pc), .out_rf_we(out_rf_we),
      .out_rf_waddr(out_rf_waddr), .out_rf_wdata(out_rf_wdata), .out_adel(out_adel),
      .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
      .fwd_pending(fwd_pending), .stallreq(stallreq));

   mem_load_stage #(.DATA_W(64), .RF_AW(5), .PC_W(32)) u_dut64 (
      .clk(clk), .rst(rst_b), .flush(flush_b), .stall_hold(stall_hold_b),
      .in_valid(in_valid_b), .in_ready(in_ready_b), .in_pc(in_pc_b), .in_rf_we(in_rf_we_b),
      .in_rf_waddr(in_rf_waddr_b), .in_ex_result(in_ex_result_b), .in_load(in_load_b),
      .in_ld_size(in_ld_size_b), .in_ld_signed(in_ld_signed_b),
      .rdata_valid(rdata_valid_b), .rdata(rdata_b),
      .out_valid(out_valid_b), .out_pc(out_pc_b), .out_rf_we(out_rf_we_b),
      .out_rf_waddr(out_rf_waddr_b), .out_rf_wdata(out_rf_wdata_b), .out_adel(out_adel_b),
      .fwd_we(fwd_we_b), .fwd_waddr(fwd_waddr_b), .fwd_wdata(fwd_wdata_b),
      .fwd_pending(fwd_pending_b), .stallreq(stallreq_b));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference load result: pick the addressed bytes arithmetically, then extend.
   function automatic logic [63:0] ref_load(input int dw, input logic [63:0] rd,
                                            input int off, input int size, input bit sgn);
      int          nbytes;
      logic [63:0] lane;
      logic [63:0] span;
      nbytes = 1 << size;
      lane   = rd / (64'd1 << (8 * off));
      if (nbytes < 8) begin
         span = 64'd1 << (8 * nbytes);
         lane = lane % span;
         if (sgn && lane >= span / 2) lane = lane - span;
      end
      if (dw == 32) lane = lane % (64'd1 << 32);
      return lane;
   endfunction

   task automatic idle32();
      flush = 1'b0; stall_hold = 1'b0; in_valid = 1'b0; in_rf_we = 1'b0; in_load = 1'b0;
      in_ld_signed = 1'b0; rdata_valid = 1'b0; in_pc = 32'd0; in_ex_result = 32'd0;
      rdata = 32'd0; in_rf_waddr = 5'd0; in_ld_size = 2'd0;
   endtask

   task automatic offer_alu(input logic [31:0] val, input logic [4:0] wa);
      in_valid = 1'b1; in_load = 1'b0; in_rf_we = 1'b1; in_rf_waddr = wa;
      in_ex_result = val; in_pc = val ^ 32'h0000_1000;
   endtask

   // One complete transaction from an empty stage: accept, optional wait, DONE, stall, consume.
   task automatic do_txn(input bit ld, input logic [1:0] sz, input bit sg, input logic [31:0] addr,
                         input logic [31:0] rd, input int d, input int k, output logic [31:0] got);
      logic [31:0] pc;
      logic [4:0]  wa;
      bit          we, illegal;
      logic [31:0] expw;
      pc = $urandom; wa = 5'($urandom); we = 1'($urandom);
      illegal = ld && (((addr % (32'd1 << sz)) != 32'd0) || (sz == 2'd3));
      in_valid = 1'b1; in_pc = pc; in_rf_we = we; in_rf_waddr = wa; in_ex_result = addr;
      in_load = ld; in_ld_size = sz; in_ld_signed = sg;
      #1 chk("accept_ready", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0; in_ex_result = $urandom; in_pc = $urandom; in_rf_waddr = 5'($urandom);
      expw = addr;
      if (ld && !illegal) begin
         for (int i = 0; i < d; i++) begin
            #1;
            chk("wait_stallreq", 64'(stallreq), 64'd1);
            chk("wait_pending", 64'(fwd_pending), 64'd1);
            chk("wait_no_valid", 64'(out_valid), 64'd0);
            tick();
         end
         rdata_valid = 1'b1; rdata = rd;
         #1;
         chk("resp_stallreq", 64'(stallreq), 64'd1);
         chk("resp_fwd_waddr", 64'(fwd_waddr), 64'(wa));
         tick();
         rdata_valid = 1'b0; rdata = $urandom;
         expw = ref_load(32, 64'(rd), int'(addr % 32'd4), int'(sz), sg);
      end
      #1;
      chk("done_valid", 64'(out_valid), 64'd1);
      chk("done_pc", 64'(out_pc), 64'(pc));
      chk("done_waddr", 64'(out_rf_waddr), 64'(wa));
      chk("done_we", 64'(out_rf_we), 64'(we && !illegal));
      chk("done_adel", 64'(out_adel), 64'(illegal));
      chk("done_fwd_we", 64'(fwd_we), 64'(we && !illegal));
      chk("done_stallreq", 64'(stallreq), 64'd0);
      if (!illegal) begin
         chk("done_wdata", 64'(out_rf_wdata), 64'(expw));
         chk("done_fwd_wdata", 64'(fwd_wdata), 64'(expw));
      end
      got = out_rf_wdata;
      stall_hold = 1'b1; rdata_valid = 1'b1; rdata = $urandom;
      offer_alu($urandom, 5'($urandom));
      for (int i = 0; i < k; i++) begin
         #1;
         chk("hold_ready", 64'(in_ready), 64'd0);
         chk("hold_valid", 64'(out_valid), 64'd1);
         chk("hold_adel", 64'(out_adel), 64'(illegal));
         chk("hold_pc", 64'(out_pc), 64'(pc));
         if (!illegal) chk("hold_wdata", 64'(out_rf_wdata), 64'(expw));
         tick();
      end
      stall_hold = 1'b0; rdata_valid = 1'b0; in_valid = 1'b0;
      #1 chk("release_ready", 64'(in_ready), 64'd1);
      tick();
      #1 chk("consumed_idle", 64'(out_valid), 64'd0);
   endtask

   task automatic txn64(input logic [1:0] sz, input logic [63:0] addr, input logic [63:0] rd,
                        input logic [63:0] exp);
      in_valid_b = 1'b1; in_load_b = 1'b1; in_rf_we_b = 1'b1; in_rf_waddr_b = 5'd9;
      in_ld_size_b = sz; in_ld_signed_b = 1'b1; in_ex_result_b = addr;
      tick();
      in_valid_b = 1'b0;
      #1 chk("w64_stallreq", 64'(stallreq_b), 64'd1);
      tick();
      rdata_valid_b = 1'b1; rdata_b = rd;
      tick();
      rdata_valid_b = 1'b0; rdata_b = 64'd0;
      #1;
      chk("w64_valid", 64'(out_valid_b), 64'd1);
      chk("w64_adel", 64'(out_adel_b), 64'd0);
      chk("w64_wdata", out_rf_wdata_b, exp);
      tick();
      #1 chk("w64_idle", 64'(out_valid_b), 64'd0);
   endtask

   logic [31:0] got;
   logic [31:0] vals [3];

   initial begin
      idle32();
      rst = 1'b1;
      rst_b = 1'b1; flush_b = 1'b0; stall_hold_b = 1'b0; in_valid_b = 1'b0; in_rf_we_b = 1'b0;
      in_load_b = 1'b0; in_ld_signed_b = 1'b0; rdata_valid_b = 1'b0; in_pc_b = 32'd0;
      in_ex_result_b = 64'd0; rdata_b = 64'd0; in_rf_waddr_b = 5'd0; in_ld_size_b = 2'd0;
      in_valid = 1'b1;
      tick();
      #1 chk("rst_ready_low", 64'(in_ready), 64'd0);
      tick();
      rst = 1'b0; rst_b = 1'b0; in_valid = 1'b0;
      #1;
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_wdata", 64'(out_rf_wdata), 64'd0);
      chk("rst_pc", 64'(out_pc), 64'd0);
      chk("rst_stallreq", 64'(stallreq), 64'd0);
      chk("rst_ready", 64'(in_ready), 64'd1);

      // Response in IDLE is ignored.
      rdata_valid = 1'b1; rdata = 32'hDEAD_BEEF;
      tick();
      rdata_valid = 1'b0;
      #1 chk("idle_resp_ignored", 64'(out_valid), 64'd0);

      // Signed byte load, two-cycle response delay.
      do_txn(1'b1, 2'd0, 1'b1, 32'h0000_1003, 32'h80FF_1234, 2, 1, got);
      chk("lb_value", 64'(got), 64'h0000_0000_FFFF_FF80);
      do_txn(1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'hBEEF_0000, 0, 0, got);
      chk("lhu_value", 64'(got), 64'h0000_0000_0000_BEEF);
      do_txn(1'b1, 2'd1, 1'b1, 32'h0000_2001, 32'h1234_5678, 0, 1, got);
      do_txn(1'b0, 2'd0, 1'b0, 32'h0BAD_F00D, 32'h0, 0, 0, got);

      // Back-to-back ALU results, first without and then with a stall on the second.
      for (int pass = 0; pass < 2; pass++) begin
         for (int i = 0; i < 3; i++) vals[i] = $urandom;
         offer_alu(vals[0], 5'd1);
         tick();
         for (int i = 1; i < 3; i++) begin
            offer_alu(vals[i], 5'(i + 1));
            #1;
            chk("b2b_valid", 64'(out_valid), 64'd1);
            chk("b2b_wdata", 64'(out_rf_wdata), 64'(vals[i-1]));
            chk("b2b_ready", 64'(in_ready), 64'd1);
            tick();
            if (pass == 1 && i == 1) begin
               offer_alu(vals[2], 5'd3);
               stall_hold = 1'b1;
               for (int s = 0; s < 2; s++) begin
                  #1;
                  chk("b2b_hold_ready", 64'(in_ready), 64'd0);
                  chk("b2b_hold_wdata", 64'(out_rf_wdata), 64'(vals[1]));
                  chk("b2b_hold_waddr", 64'(out_rf_waddr), 64'd2);
                  tick();
               end
               stall_hold = 1'b0;
            end
         end
         in_valid = 1'b0;
         #1;
         chk("b2b_last_valid", 64'(out_valid), 64'd1);
         chk("b2b_last_wdata", 64'(out_rf_wdata), 64'(vals[2]));
         tick();
         #1 chk("b2b_empty", 64'(out_valid), 64'd0);
      end

      // Flush in WAIT: new entry waits for the orphan response to drain.
      in_valid = 1'b1; in_load = 1'b1; in_ld_size = 2'd2; in_ex_result = 32'h0000_0040;
      in_rf_we = 1'b1; in_rf_waddr = 5'd7;
      tick();
      in_valid = 1'b0; flush = 1'b1;
      tick();
      flush = 1'b0;
      offer_alu(32'h1357_9BDF, 5'd8);
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("drain_ready", 64'(in_ready), 64'd0);
         chk("drain_stallreq", 64'(stallreq), 64'd1);
         chk("drain_fwd_we", 64'(fwd_we), 64'd0);
         tick();
      end
      rdata_valid = 1'b1; rdata = 32'hCAFE_CAFE;
      #1 chk("drain_resp_ready", 64'(in_ready), 64'd0);
      tick();
      rdata_valid = 1'b0;
      #1 chk("after_drain_ready", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      #1;
      chk("after_drain_valid", 64'(out_valid), 64'd1);
      chk("after_drain_wdata", 64'(out_rf_wdata), 64'h0000_0000_1357_9BDF);
      tick();

      // Reset in WAIT coincident with the response, then a late response.
      in_valid = 1'b1; in_load = 1'b1; in_ld_size = 2'd2; in_ex_result = 32'h0000_0080;
      in_rf_we = 1'b1; in_rf_waddr = 5'd5;
      tick();
      in_valid = 1'b1; rst = 1'b1; rdata_valid = 1'b1; rdata = 32'h1111_2222;
      tick();
      rst = 1'b0; in_valid = 1'b0;
      #1;
      chk("wrst_valid", 64'(out_valid), 64'd0);
      chk("wrst_wdata", 64'(out_rf_wdata), 64'd0);
      chk("wrst_we", 64'(out_rf_we), 64'd0);
      chk("wrst_waddr", 64'(out_rf_waddr), 64'd0);
      chk("wrst_pending", 64'(fwd_pending), 64'd0);
      chk("wrst_stallreq", 64'(stallreq), 64'd0);
      tick();
      rdata_valid = 1'b0;
      #1 chk("late_resp_ignored", 64'(out_valid), 64'd0);

      // Random transactions against the reference model.
      for (int n = 0; n < 40; n++) begin
         do_txn(1'(($urandom % 3) != 0), 2'($urandom), 1'($urandom), $urandom, $urandom,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), got);
      end

      // 64-bit datapath loads.
      txn64(2'd3, 64'h8, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001);
      txn64(2'd2, 64'hC, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321);
      txn64(2'd2, 64'hC, 64'h0765_4321_0000_0000, ref_load(64, 64'h0765_4321_0000_0000, 4, 2, 1'b1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
